// File: rtl/instr_prefetch_ir_if.sv
// Memory-to-prefetch fetch bus.
// Carries one instruction word per cycle under a valid/ready handshake.
//   D_MemData   fetched instruction word (memory -> queue)
//   D_MemValid  D_MemData is valid this cycle (memory -> queue)
//   D_MemReady  queue accepts a word this cycle (queue -> memory)
// Modports: master = memory side, slave = prefetch queue side.
interface instr_prefetch_ir_if #(
  parameter int unsigned IW = 16
);
  logic [IW-1:0] D_MemData;
  logic          D_MemValid;
  logic          D_MemReady;

  modport master (
    output D_MemData,
    output D_MemValid,
    input  D_MemReady
  );

  modport slave (
    input  D_MemData,
    input  D_MemValid,
    output D_MemReady
  );
endinterface

// File: rtl/instr_prefetch_ir.sv
// Instruction register fronted by a DEPTH-entry prefetch queue (16-bit multicycle core).
// Memory pushes words over mem_if; C_IRWrite pops the queue head into the IR, and the
// decoded fields are continuous slices of the IR. C_Flush drops every queued word.
// Optional feature macro: IRQ_BYPASS_EN -- when the queue is empty and a word arrives in
// the same cycle as C_IRWrite, the word goes straight into the IR instead of stalling.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   mem_if (slave)   D_MemData / D_MemValid in, D_MemReady out
//   C_IRWrite        pop queue head into IR
//   C_Flush          discard queued words (IR keeps its value)
//   C_IRStall        IRWrite requested but no word available
//   IRValid, QCount  IR-loaded flag, queue occupancy
//   OPCODE .. A_WriteRegRT_BT  decoded IR fields
module instr_prefetch_ir #(
  parameter  int unsigned IW    = 16,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  instr_prefetch_ir_if.slave mem_if,
  input  logic             C_IRWrite,
  input  logic             C_Flush,
  output logic             C_IRStall,
  output logic             IRValid,
  output logic [CNT_W-1:0] QCount,
  output logic [3:0]       OPCODE,
  output logic [3:0]       FUNCFIELD,
  output logic [3:0]       A_ReadReg1RT,
  output logic [3:0]       A_ReadReg2RT,
  output logic [1:0]       A_Offset,
  output logic [1:0]       A_RegSWLW,
  output logic [3:0]       A_WriteRegRT_BT
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [IW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [IW-1:0]    r_ir;
  logic             r_ir_valid;

  logic w_full;
  logic w_empty;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

`ifdef IRQ_BYPASS_EN
  assign w_bypass = C_IRWrite && w_empty && mem_if.D_MemValid && !C_Flush;
`else
  assign w_bypass = 1'b0;
`endif

  // Ready comes from the registered count only: a full queue refuses a push even if
  // it is popped in the same cycle.
  assign mem_if.D_MemReady = !rst && !w_full;

  // A bypassed word is consumed by the IR, so it is not also written into the queue.
  assign w_push = mem_if.D_MemValid && !w_full && !w_bypass;
  assign w_pop  = C_IRWrite && !w_empty;

  assign C_IRStall = !rst && !C_Flush && C_IRWrite && w_empty && !w_bypass;

  // Storage array: data only, no reset needed; occupancy governs what is meaningful.
  always_ff @(posedge clk) begin
    if (!rst && !C_Flush && w_push) begin
      r_mem[r_wr_ptr] <= mem_if.D_MemData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
    end else if (C_Flush) begin
      // Flush beats push and pop; IR is the instruction now executing and is kept.
      r_count  <= '0;
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_ir       <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_ir_valid <= 1'b1;
      end else if (w_bypass) begin
        r_ir       <= mem_if.D_MemData;
        r_ir_valid <= 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign IRValid = r_ir_valid;
  assign QCount  = r_count;

  assign OPCODE          = r_ir[15:12];
  assign FUNCFIELD       = r_ir[3:0];
  assign A_ReadReg1RT    = r_ir[7:4];
  assign A_ReadReg2RT    = r_ir[3:0];
  assign A_Offset        = r_ir[9:8];
  assign A_RegSWLW       = r_ir[11:10];
  assign A_WriteRegRT_BT = r_ir[11:8];

endmodule

// File: tb/tb_instr_prefetch_ir.sv
// Scoreboard bench for instr_prefetch_ir: directed scenarios followed by random traffic.
// A queue-based reference model predicts occupancy, ready, stall and the IR; each IR load
// it predicts is pushed to a scoreboard that an independent monitor drains.
module tb_instr_prefetch_ir;

  localparam int unsigned IW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             C_IRWrite;
  logic             C_Flush;
  logic             C_IRStall;
  logic             IRValid;
  logic [CNT_W-1:0] QCount;
  logic [3:0]       OPCODE;
  logic [3:0]       FUNCFIELD;
  logic [3:0]       A_ReadReg1RT;
  logic [3:0]       A_ReadReg2RT;
  logic [1:0]       A_Offset;
  logic [1:0]       A_RegSWLW;
  logic [3:0]       A_WriteRegRT_BT;

  instr_prefetch_ir_if #(.IW(IW)) mem_if ();

  instr_prefetch_ir #(
    .IW   (IW),
    .DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_if         (mem_if),
    .C_IRWrite      (C_IRWrite),
    .C_Flush        (C_Flush),
    .C_IRStall      (C_IRStall),
    .IRValid        (IRValid),
    .QCount         (QCount),
    .OPCODE         (OPCODE),
    .FUNCFIELD      (FUNCFIELD),
    .A_ReadReg1RT   (A_ReadReg1RT),
    .A_ReadReg2RT   (A_ReadReg2RT),
    .A_Offset       (A_Offset),
    .A_RegSWLW      (A_RegSWLW),
    .A_WriteRegRT_BT(A_WriteRegRT_BT)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [IW-1:0] m_q[$];
  logic [IW-1:0] m_ir = '0;
  logic          m_ir_valid = 1'b0;
  // Scoreboard of expected IR loads
  logic [IW-1:0] sb_q[$];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check and advance the model at negedge.
  task automatic cycle(input logic r, input logic v, input logic [IW-1:0] d,
                       input logic irw, input logic fl);
    int unsigned cnt;
    logic        exp_stall;
    logic        bypass;
    rst               = r;
    mem_if.D_MemValid = v;
    mem_if.D_MemData  = d;
    C_IRWrite         = irw;
    C_Flush           = fl;
    @(negedge clk);
    cnt = m_q.size();
`ifdef IRQ_BYPASS_EN
    bypass = irw && (cnt == 0) && v && !fl;
`else
    bypass = 1'b0;
`endif
    exp_stall = !r && !fl && irw && (cnt == 0) && !bypass;
    chk("QCount", QCount, cnt);
    chk("D_MemReady", mem_if.D_MemReady, (!r && cnt != DEPTH) ? 1 : 0);
    chk("C_IRStall", C_IRStall, exp_stall ? 1 : 0);
    chk("IRValid", IRValid, m_ir_valid ? 1 : 0);
    chk("IR_bits", {OPCODE, A_WriteRegRT_BT, A_ReadReg1RT, FUNCFIELD}, m_ir);
    chk("A_Offset", A_Offset, m_ir[9:8]);
    chk("A_RegSWLW", A_RegSWLW, m_ir[11:10]);
    chk("A_ReadReg2RT", A_ReadReg2RT, m_ir[3:0]);
    // Advance the model to the state after the coming edge
    if (r) begin
      m_q.delete();
      m_ir       = '0;
      m_ir_valid = 1'b0;
    end else if (fl) begin
      m_q.delete();
    end else if (bypass) begin
      m_ir       = d;
      m_ir_valid = 1'b1;
      sb_q.push_back(d);
    end else begin
      if (irw && cnt != 0) begin
        m_ir       = m_q.pop_front();
        m_ir_valid = 1'b1;
        sb_q.push_back(m_ir);
      end
      if (v && cnt != DEPTH) m_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: an IR load is signalled by a granted C_IRWrite; compare fields after the edge.
  initial begin
    logic          seen;
    logic [IW-1:0] w;
    forever begin
      @(negedge clk);
      seen = !rst && C_IRWrite && !C_IRStall && !C_Flush;
      @(posedge clk);
      #2;
      if (seen) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: got IR 0x%0h expected no load at %0t",
                   {OPCODE, A_WriteRegRT_BT, A_ReadReg1RT, FUNCFIELD}, $time);
        end else begin
          w = sb_q.pop_front();
          chk("load_OPCODE", OPCODE, w[15:12]);
          chk("load_FUNCFIELD", FUNCFIELD, w[3:0]);
          chk("load_ReadReg1RT", A_ReadReg1RT, w[7:4]);
          chk("load_ReadReg2RT", A_ReadReg2RT, w[3:0]);
          chk("load_Offset", A_Offset, w[9:8]);
          chk("load_RegSWLW", A_RegSWLW, w[11:10]);
          chk("load_WriteRegRT_BT", A_WriteRegRT_BT, w[11:8]);
        end
      end
    end
  end

  initial begin
    logic [IW-1:0] fill [4];
    fill[0] = 16'h8B48;
    fill[1] = 16'h9BC9;
    fill[2] = 16'hABC9;
    fill[3] = 16'hCB48;
    rst = 1'b1;
    mem_if.D_MemValid = 1'b0;
    mem_if.D_MemData  = '0;
    C_IRWrite = 1'b0;
    C_Flush   = 1'b0;
    @(posedge clk);
    #1;
    // Reset for two cycles
    cycle(1, 0, 16'h0, 0, 0);
    cycle(1, 1, 16'h1234, 1, 0);
    // Fill the queue, then one refused push
    for (int i = 0; i < 4; i++) cycle(0, 1, fill[i], 0, 0);
    cycle(0, 1, 16'h5555, 0, 0);
    // Drain in order
    for (int i = 0; i < 4; i++) cycle(0, 0, 16'h0, 1, 0);
    // Stall on empty queue, IR holds
    cycle(0, 0, 16'h0, 1, 0);
    cycle(0, 0, 16'h0, 1, 0);
    // Word arriving with IRWrite on empty queue (bypass or push+stall)
    cycle(0, 1, 16'h2BC9, 1, 0);
    cycle(0, 0, 16'h0, 1, 0);
    cycle(0, 0, 16'h0, 0, 0);
    // Build QCount=3 then collide push, pop and flush
    while (m_q.size() < 3) cycle(0, 1, 16'($urandom), 0, 0);
    cycle(0, 1, 16'h7E11, 1, 1);
    cycle(0, 0, 16'h0, 0, 0);
    // Wrap: hold one word and stream 10 push/pop pairs
    cycle(0, 1, 16'h1001, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 16'(16'h3000 + i * 16'h0111), 1, 0);
    cycle(0, 0, 16'h0, 0, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6), 16'($urandom),
            ($urandom_range(0, 9) < 5), ($urandom_range(0, 39) == 0));
    end
    cycle(0, 0, 16'h0, 0, 0);
    cycle(0, 0, 16'h0, 0, 0);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
